// File: rtl/seg7_score_display_pkg.sv
// rtl/seg7_score_display_pkg.sv - shared segment patterns and helpers for scoreboard displays
// Purpose: active-low gfedcba patterns for the digits, blank and dash, plus a
//          constant power-of-ten helper used for the overflow threshold.
// Ports:   none (package).
package seg7_score_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;

  // Evaluated at elaboration only; 10^8 still fits comfortably in 64 bits.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// rtl/seg7_digit_decode.sv - BCD nibble to active-low 7-segment decoder
// Purpose: combinational decode of one digit; non-decimal nibbles show blank.
// Ports:   nibble (in, 4)  BCD digit
//          blank  (in, 1)  force all segments off
//          seg    (out, 7) active-low gfedcba
module seg7_digit_decode
  import seg7_score_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_score_display.sv
// rtl/seg7_score_display.sv - binary score to multi-digit active-low 7-segment driver
// Purpose: captures a binary value on load, converts it to BCD one bit per clock
//          (shift-add-3), then drives registered segments with leading-zero
//          blanking, overflow dashes and a free-running blink.
// Ports:   clk, reset (async, active-high)
//          value    (in, BIN_WIDTH)     binary value, sampled on accepted load
//          load     (in, 1)             capture request, dropped while busy
//          blank_lz (in, 1)             blank leading zeros (digit 0 always shown)
//          blink_en (in, 1)             blank everything in blink off-phase
//          segments (out, 7*NUM_DIGITS) active-low, digit k at [7k+6:7k]
//          busy     (out, 1)            conversion in progress
//          overflow (out, 1)            last accepted value >= 10^NUM_DIGITS
module seg7_score_display
  import seg7_score_display_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 7,
  parameter int BLINK_DIV  = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] segments,
  output logic                    busy,
  output logic                    overflow
);

  localparam int          BCD_W     = 4 * NUM_DIGITS;
  localparam int          CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  logic [0:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BIN_WIDTH-1:0] shreg;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     held;
  logic [BLINK_DIV-1:0] blink_cnt;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_shift;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic [6:0]              dec [NUM_DIGITS];
  logic                    blink_off;

  assign busy      = (state == ST_CONV);
  assign blink_off = blink_en && blink_cnt[BLINK_DIV-1];

  // Add-3 correction before the shift; the carry out of the top nibble is
  // discarded because overflow already flags values that need it.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
    bcd_shift = (bcd_adj << 1) | BCD_W'(shreg[BIN_WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      bcd      <= '0;
      held     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg    <= value;
            bcd      <= '0;
            bit_cnt  <= CNT_W'(BIN_WIDTH);
            overflow <= (64'(value) >= OVF_LIMIT);
            state    <= ST_CONV;
          end
        end
        default: begin
          bcd     <= bcd_shift;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == CNT_W'(1)) begin
            held  <= bcd_shift;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < NUM_DIGITS; gk++) begin : g_digit
      logic lz_blank;
      if (gk == 0) begin : g_lsd
        assign lz_blank = 1'b0;
      end else begin : g_upper
        // Blank only when this digit and every more significant one are zero.
        assign lz_blank = blank_lz && (held[BCD_W-1:4*gk] == '0);
      end
      seg7_digit_decode u_dec (
        .nibble (held[4*gk +: 4]),
        .blank  (lz_blank),
        .seg    (dec[gk])
      );
    end
  endgenerate

  always_comb begin
    seg_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (blink_off) begin
        seg_next[7*k +: 7] = SEG_BLANK;
      end else if (overflow) begin
        seg_next[7*k +: 7] = SEG_DASH;
      end else begin
        seg_next[7*k +: 7] = dec[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segments <= '1;
    end else begin
      segments <= seg_next;
    end
  end

endmodule
